// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, mode encodings and angle rescaling.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // atan(2^-i) with 2^32 = one full turn
  localparam logic [31:0] CORDIC_ATAN_32 [0:23] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };

  function automatic logic [31:0] atan_scaled(input int i, input int aw);
    logic [32:0] sum;
    if (aw >= 32) return CORDIC_ATAN_32[i];
    sum = {1'b0, CORDIC_ATAN_32[i]} + (33'd1 << (31 - aw));
    return 32'(sum >> (32 - aw));
  endfunction

endpackage

// File: rtl/cordic_pipe_multi_stage.sv
// One registered CORDIC micro-rotation; direction comes from Z (rotation) or Y (vectoring).
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int DW    = 16,
  parameter int AW    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_mode,
  input  logic signed [DW+1:0] in_x,
  input  logic signed [DW+1:0] in_y,
  input  logic        [AW-1:0] in_z,
  output logic                 out_valid,
  output logic                 out_mode,
  output logic signed [DW+1:0] out_x,
  output logic signed [DW+1:0] out_y,
  output logic        [AW-1:0] out_z
);

  localparam int XW = DW + 2;
  localparam logic [31:0]   ATAN_FULL = atan_scaled(SHIFT, AW);
  localparam logic [AW-1:0] ATAN      = ATAN_FULL[AW-1:0];

  logic signed [XW-1:0] x_sh, y_sh, x_next, y_next;
  logic        [AW-1:0] z_next;
  logic                 dir_pos;

  assign x_sh    = in_x >>> SHIFT;
  assign y_sh    = in_y >>> SHIFT;
  assign dir_pos = (in_mode == MODE_VEC) ? in_y[XW-1] : ~in_z[AW-1];

  always_comb begin
    if (dir_pos) begin
      x_next = in_x - y_sh;
      y_next = in_y + x_sh;
      z_next = in_z - ATAN;
    end else begin
      x_next = in_x + y_sh;
      y_next = in_y - x_sh;
      z_next = in_z + ATAN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (ce) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_x     <= x_next;
      out_y     <= y_next;
      out_z     <= z_next;
    end
  end

endmodule

// File: rtl/cordic_pipe_multi.sv
// Pipelined multi-mode CORDIC: registered quadrant fold followed by STG micro-rotation stages.
module cordic_pipe_multi
  import cordic_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 32,
  parameter int STG = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_mode,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic        [AW-1:0] in_z,
  output logic                 out_valid,
  output logic                 out_mode,
  output logic signed [DW+1:0] out_x,
  output logic signed [DW+1:0] out_y,
  output logic        [AW-1:0] out_z
);

  localparam int XW      = DW + 2;
  localparam int STG_MAX = (AW - 2 < 24) ? AW - 2 : 24;
  localparam logic [AW-1:0] QUARTER = {2'b01, {(AW-2){1'b0}}};

  generate
    if (STG < 4 || STG > STG_MAX) begin : g_bad_stg
      $error("cordic_pipe_multi: STG out of range");
    end
  endgenerate

  logic signed [XW-1:0] x_pipe [0:STG];
  logic signed [XW-1:0] y_pipe [0:STG];
  logic        [AW-1:0] z_pipe [0:STG];
  logic                 v_pipe [0:STG];
  logic                 m_pipe [0:STG];

  logic signed [XW-1:0] ix, iy, fx_next, fy_next;
  logic        [AW-1:0] fz_next;

  // Widen before negating so the most negative input negates exactly
  assign ix = {{2{in_x[DW-1]}}, in_x};
  assign iy = {{2{in_y[DW-1]}}, in_y};

  always_comb begin
    fx_next = ix;
    fy_next = iy;
    fz_next = in_z;
    if (in_mode == MODE_ROT) begin
      case (in_z[AW-1:AW-2])
        2'b01: begin fx_next = -iy; fy_next = ix;  fz_next = in_z - QUARTER; end
        2'b10: begin fx_next = iy;  fy_next = -ix; fz_next = in_z + QUARTER; end
        default: ;
      endcase
    end else if (ix[XW-1]) begin
      if (!iy[XW-1]) begin
        fx_next = iy;  fy_next = -ix; fz_next = in_z + QUARTER;
      end else begin
        fx_next = -iy; fy_next = ix;  fz_next = in_z - QUARTER;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_pipe[0] <= 1'b0;
      m_pipe[0] <= 1'b0;
      x_pipe[0] <= '0;
      y_pipe[0] <= '0;
      z_pipe[0] <= '0;
    end else if (ce) begin
      v_pipe[0] <= in_valid;
      m_pipe[0] <= in_mode;
      x_pipe[0] <= fx_next;
      y_pipe[0] <= fy_next;
      z_pipe[0] <= fz_next;
    end
  end

  generate
    for (genvar gi = 0; gi < STG; gi++) begin : g_stage
      cordic_stage #(.SHIFT(gi), .DW(DW), .AW(AW)) u_stage (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .in_valid (v_pipe[gi]),
        .in_mode  (m_pipe[gi]),
        .in_x     (x_pipe[gi]),
        .in_y     (y_pipe[gi]),
        .in_z     (z_pipe[gi]),
        .out_valid(v_pipe[gi+1]),
        .out_mode (m_pipe[gi+1]),
        .out_x    (x_pipe[gi+1]),
        .out_y    (y_pipe[gi+1]),
        .out_z    (z_pipe[gi+1])
      );
    end
  endgenerate

  assign out_valid = v_pipe[STG];
  assign out_mode  = m_pipe[STG];
  assign out_x     = x_pipe[STG];
  assign out_y     = y_pipe[STG];
  assign out_z     = z_pipe[STG];

endmodule

// File: tb/tb_cordic_pipe_multi.sv
// Self-checking bench for cordic_pipe_multi against a floating-point rotation/vectoring model.
module tb_cordic_pipe_multi;

  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int STG = 12;
  localparam int LAT = STG + 1;
  localparam real PI = 3.14159265358979323846;
  localparam real TURN = 4294967296.0;

  typedef struct {
    bit          v;
    bit          m;
    int          x;
    int          y;
    logic [31:0] z;
    int          ta;
    int          tz;
  } rec_t;

  logic                 clock, reset, ce, in_valid, in_mode;
  logic signed [DW-1:0] in_x, in_y;
  logic        [AW-1:0] in_z;
  logic                 out_valid, out_mode;
  logic signed [DW+1:0] out_x, out_y;
  logic        [AW-1:0] out_z;

  cordic_pipe_multi #(.DW(DW), .AW(AW), .STG(STG)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_mode (out_mode),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  real  kgain;
  rec_t pend[$];
  logic                 prev_v, prev_m;
  logic signed [DW+1:0] prev_x, prev_y;
  logic        [AW-1:0] prev_z;

  task automatic chk(input string tag, input bit ok, input longint act, input longint expv);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, expv);
    end
  endtask

  function automatic longint rnd(input real r);
    return (r >= 0.0) ? longint'($floor(r + 0.5)) : -longint'($floor(-r + 0.5));
  endfunction

  function automatic rec_t mk(input bit m, input int x, input int y, input logic [31:0] z);
    rec_t r;
    r.v = 1'b1; r.m = m; r.x = x; r.y = y; r.z = z; r.ta = 16; r.tz = 32'h00060000;
    return r;
  endfunction

  function automatic rec_t rand_rec(input bit m, input bit v);
    rec_t r;
    real mag, phi;
    mag = real'($urandom_range(14000, 6000));
    phi = real'($urandom) * 2.0 * PI / TURN;
    r.v = v; r.m = m;
    r.x = int'(rnd(mag * $cos(phi)));
    r.y = int'(rnd(mag * $sin(phi)));
    r.z = $urandom;
    r.ta = 32; r.tz = 32'h000C0000;
    return r;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.v = 1'b0; r.m = 1'b0; r.x = 0; r.y = 0; r.z = '0; r.ta = 0; r.tz = 0;
    return r;
  endfunction

  task automatic check_out(input rec_t r);
    real th, ex, ey;
    longint ez, dx, dy;
    logic [31:0] ezb, dz;
    chk("out_valid", out_valid === 1'b1, longint'(out_valid), 1);
    chk("out_mode", out_mode === r.m, longint'(out_mode), longint'(r.m));
    if (r.m == 1'b0) begin
      th = real'($signed(r.z)) * 2.0 * PI / TURN;
      ex = kgain * (real'(r.x) * $cos(th) - real'(r.y) * $sin(th));
      ey = kgain * (real'(r.x) * $sin(th) + real'(r.y) * $cos(th));
      ezb = '0;
    end else begin
      ex = kgain * $sqrt(real'(r.x) * real'(r.x) + real'(r.y) * real'(r.y));
      ey = 0.0;
      ez = longint'(r.z) + rnd($atan2(real'(r.y), real'(r.x)) * TURN / (2.0 * PI));
      ezb = ez[31:0];
    end
    dx = longint'(out_x) - rnd(ex);
    dy = longint'(out_y) - rnd(ey);
    dz = out_z - ezb;
    chk("out_x", dx <= r.ta && dx >= -r.ta, longint'(out_x), rnd(ex));
    chk("out_y", dy <= r.ta && dy >= -r.ta, longint'(out_y), rnd(ey));
    chk("out_z", $signed(dz) <= r.tz && $signed(dz) >= -r.tz, longint'(out_z), longint'(ezb));
    $display("tx mode=%0d in=(%0d,%0d,%h) out=(%0d,%0d,%h)", r.m, r.x, r.y, r.z, out_x, out_y, out_z);
  endtask

  task automatic step(input rec_t r, input bit c);
    rec_t e;
    ce       = c;
    in_valid = r.v;
    in_mode  = r.m;
    in_x     = 16'(r.x);
    in_y     = 16'(r.y);
    in_z     = r.z;
    @(posedge clock);
    #1;
    if (c) begin
      pend.push_back(r);
      if (pend.size() == LAT) begin
        e = pend.pop_front();
        if (e.v) check_out(e);
        else chk("out_valid_idle", out_valid === 1'b0, longint'(out_valid), 0);
      end else begin
        chk("out_valid_fill", out_valid === 1'b0, longint'(out_valid), 0);
      end
    end else begin
      chk("hold_valid", out_valid === prev_v, longint'(out_valid), longint'(prev_v));
      chk("hold_x", out_x === prev_x, longint'(out_x), longint'(prev_x));
      chk("hold_z", out_z === prev_z, longint'(out_z), longint'(prev_z));
    end
    prev_v = out_valid; prev_m = out_mode;
    prev_x = out_x; prev_y = out_y; prev_z = out_z;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid === 1'b0, longint'(out_valid), 0);
    chk({tag, "_mode"}, out_mode === 1'b0, longint'(out_mode), 0);
    chk({tag, "_x"}, out_x === '0, longint'(out_x), 0);
    chk({tag, "_y"}, out_y === '0, longint'(out_y), 0);
    chk({tag, "_z"}, out_z === '0, longint'(out_z), 0);
  endtask

  initial begin
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    kgain = 1.0;
    for (int i = 0; i < STG; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    prev_v = 1'b0; prev_m = 1'b0; prev_x = '0; prev_y = '0; prev_z = '0;

    // Directed points, back to back
    step(mk(1'b0, 19898, 0, 32'h00000000), 1'b1);
    step(mk(1'b0, 19898, 0, 32'h40000000), 1'b1);
    step(mk(1'b0, 19898, 0, 32'h80000000), 1'b1);
    step(mk(1'b0, 19898, 0, 32'hC0000000), 1'b1);
    step(mk(1'b0, 19898, 0, 32'h20000000), 1'b1);
    step(mk(1'b1, 10000, 10000, 32'h00000000), 1'b1);
    step(mk(1'b1, -10000, 0, 32'h00000000), 1'b1);
    step(mk(1'b1, 0, -32768, 32'h00000000), 1'b1);
    step(mk(1'b1, -20000, -15000, 32'h10000000), 1'b1);
    for (int i = 0; i < LAT + 1; i++) step(idle_rec(), 1'b1);

    // Alternating-mode stream with valid gaps
    for (int i = 0; i < 64; i++)
      step(rand_rec(i[0], $urandom_range(3, 0) != 0), 1'b1);

    // Same stream shape with a 1,0,0,1 clock-enable pattern
    for (int i = 0; i < 64; i++)
      step(rand_rec(i[0], $urandom_range(3, 0) != 0), pat[i % 4]);
    for (int i = 0; i < LAT + 1; i++) step(idle_rec(), 1'b1);

    // Full pipeline, then an asynchronous reset 5 cycles in
    for (int i = 0; i < LAT + 5; i++) step(rand_rec(i[0], 1'b1), 1'b1);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) begin
      @(posedge clock);
      #1 check_zero("reset_hold");
    end
    reset = 1'b0;
    pend.delete();
    prev_v = 1'b0; prev_m = 1'b0; prev_x = '0; prev_y = '0; prev_z = '0;
    for (int i = 0; i < 3; i++) step(rand_rec(i[0], 1'b1), 1'b1);
    for (int i = 0; i < LAT + 2; i++) step(idle_rec(), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_pipe_multi.md
Name: cordic_pipe_multi

Overview:
Parametrised, fully pipelined CORDIC engine for the NCO datapath. It succeeds the fixed 16-bit, 10-stage rotator. Data width, angle width and stage count are configurable. Each sample carries its own mode bit selecting rotation (sin/cos generation, phase shift) or vectoring (magnitude/phase extraction). It adds valid tracking, a global clock-enable stall, and async reset, so it sits directly behind the phase accumulator or a downstream demodulator.

Parameters:
DW, 16, input X/Y width (signed, two's complement)
AW, 32, angle width; full scale 2^AW = 360 deg (0x2000_0000 = 45 deg at AW=32)
STG, 12, micro-rotation stages; legal 4..min(AW-2, 24), elaboration error otherwise

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears valid chain and outputs
ce  in  1  clock enable; low freezes every pipeline register, including valid
in_valid  in  1  sample present on inputs this cycle (sampled only when ce=1)
in_mode  in  1  0 = rotation, 1 = vectoring
in_x  in  DW  signed X
in_y  in  DW  signed Y
in_z  in  AW  signed angle; rotation: target angle; vectoring: phase offset added to result
out_valid  out  1  result valid
out_mode  out  1  mode of the emerging sample
out_x  out  DW+2  signed X result (CORDIC gain K~1.6468 not removed)
out_y  out  DW+2  signed Y result
out_z  out  AW  residual angle (rotation) / accumulated phase (vectoring)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. On reset, all out_* = 0 and every internal valid bit = 0. Reset asserted mid-stream discards in-flight samples. The first out_valid after release is at least STG+1 ce-cycles after the next accepted in_valid.
- Pipeline: stage 0 = sign-extend to DW+2 plus quadrant fold (registered), then STG iteration registers; latency = STG+1 ce-enabled cycles; throughput 1 sample/cycle, no backpressure.
- ce=0: no register updates; outputs hold; in_valid ignored that cycle.
- Invalid samples flow through the pipeline. X/Y/Z contents are don't-care when valid=0, but out_* must be driven from the pipeline (no gating required).
- Rotation fold, on angle MSBs [AW-1:AW-2]:
  - 00/11: pass.
  - 01: X=-Y, Y=X, Z=angle-quarter.
  - 10: X=Y, Y=-X, Z=angle+quarter.
  - quarter = 2^(AW-2). Z wraps modulo 2^AW.
- Vectoring fold:
  - X>=0: pass.
  - X<0 and Y>=0: X=Y, Y=-X, Z=in_z+quarter.
  - X<0 and Y<0: X=-Y, Y=X, Z=in_z-quarter.
- Stage i direction d:
  - Rotation: d=+1 if Z>=0, else -1.
  - Vectoring: d=+1 if Y<0, else -1.
  - Update: X'=X-d*(Y>>>i); Y'=Y+d*(X>>>i); Z'=Z-d*atan[i].
- Arithmetic:
  - Negation is performed after sign extension, so -(-2^(DW-1)) is exact.
  - Shifts are arithmetic; no rounding, no saturation.
  - DW+2 bits cover K*sqrt2 growth.
  - Z adds wrap modulo 2^AW.
- atan[i] = package 32-bit constant >>> (32-AW) with round-half-up.
- out_mode tracks the sample's mode through the pipeline. Mixed modes back-to-back are legal.

Decomposition:
- Package cordic_pkg:
  - CORDIC_ATAN_32[0:23] constant table (2^32 = 360 deg; entries 0..9 = 0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4, 0x028B0D43, 0x0145D7E1, 0x00A2F61E, 0x00517C55, 0x0028BE53, 0x00145F2F, extended to 24).
  - MODE_ROT=0 and MODE_VEC=1 constants.
  - Function atan_scaled(i, AW).
- Sub-module cordic_stage: one registered micro-rotation with parameters SHIFT, DW, AW, and ports for ce, valid and mode. Instantiate STG times via generate.

Test Plan:
Defaults DW=16, AW=32, STG=12. Amplitude tolerance ±16 LSB; angle tolerance ±0x00060000.
- Rotation in_x=19898, in_y=0, in_z=0 -> out_x~32767, out_y~0; out_valid exactly 13 cycles after in_valid.
- Rotation quadrants, same X: in_z=0x40000000 -> (0, 32767); 0x80000000 -> (-32767, 0); 0xC0000000 -> (0, -32767); 0x20000000 -> (23170, 23170).
- Vectoring:
  - (10000, 10000, 0) -> out_x~23290, out_y~0, out_z~0x20000000.
  - (-10000, 0, 0) -> out_x~16468, out_z~0x80000000.
  - (0, -32768, 0) -> out_x~53961 (no overflow), out_z~0xC0000000.
- Back-to-back stream of 64 samples alternating mode each cycle, in_valid gaps included -> output sequence, modes and valid pattern match the reference model 1:1, shifted 13 cycles.
- ce toggled 1,0,0,1 pattern during stream -> latency counted in ce-high cycles only; outputs frozen during ce=0; no sample lost or duplicated.
- reset asserted 5 cycles into a full pipeline, 3 cycles wide -> out_* = 0 and out_valid = 0 immediately (asynchronous); no stale sample emerges after release.
